// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - two-lane input and two-bin output streams of the FFT output reorder buffer
interface fft_out_reorder_if #(
    parameter int WIDTH = 9
);
    logic                    in_valid;
    logic                    in_first;
    logic signed [WIDTH-1:0] inUp_re;
    logic signed [WIDTH-1:0] inUp_im;
    logic signed [WIDTH-1:0] inL_re;
    logic signed [WIDTH-1:0] inL_im;
    logic                    out_valid;
    logic                    out_first;
    logic signed [WIDTH-1:0] outEven_re;
    logic signed [WIDTH-1:0] outEven_im;
    logic signed [WIDTH-1:0] outOdd_re;
    logic signed [WIDTH-1:0] outOdd_im;

    modport slave (
        input  in_valid, in_first, inUp_re, inUp_im, inL_re, inL_im,
        output out_valid, out_first, outEven_re, outEven_im, outOdd_re, outOdd_im
    );

    modport master (
        output in_valid, in_first, inUp_re, inUp_im, inL_re, inL_im,
        input  out_valid, out_first, outEven_re, outEven_im, outOdd_re, outOdd_im
    );
endinterface

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural order reorder buffer for the 32-point FFT
module fft_out_reorder #(
    parameter int WIDTH = 9
) (
    input logic              clk,
    input logic              rst_n,
    fft_out_reorder_if.slave bus
);
    localparam int EW = 4 * WIDTH;

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Entry layout: {up_re, up_im, l_re, l_im}; contents are never reset
    logic [EW-1:0] mem0 [16];
    logic [EW-1:0] mem1 [16];

    state_t state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    logic [1:0] full_q, full_d;
    logic       out_valid_q, out_valid_d;
    logic       out_first_q, out_first_d;
    logic signed [WIDTH-1:0] even_re_q, even_re_d;
    logic signed [WIDTH-1:0] even_im_q, even_im_d;
    logic signed [WIDTH-1:0] odd_re_q, odd_re_d;
    logic signed [WIDTH-1:0] odd_im_q, odd_im_d;

    logic          wr_en;
    logic          wr_done;
    logic [3:0]    wr_addr;
    logic [EW-1:0] wr_word;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic [1:0]    full_pre;
    logic          rd_en;
    logic          rd_bank;
    logic          other_bank;
    logic [3:0]    rd_cnt;
    logic [3:0]    rd_addr;
    logic [EW-1:0] rd_word;

    // Write side: in_first restarts the frame at address 0, dropping any partial frame
    always_comb begin
        wr_en    = bus.in_valid;
        wr_addr  = bus.in_first ? 4'd0 : wcnt_q;
        wr_word  = {bus.inUp_re, bus.inUp_im, bus.inL_re, bus.inL_im};
        wr_done  = wr_en && (wr_addr == 4'd15);
        wcnt_d   = wr_en ? (wr_addr + 4'd1) : wcnt_q;
        wbank_d  = wr_done ? ~wbank_q : wbank_q;
        full_set = 2'b00;
        if (wr_done) begin
            full_set = wbank_q ? 2'b10 : 2'b01;
        end
    end

    // Bank storage; only the current write bank is written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wbank_q) begin
                mem1[wr_addr] <= wr_word;
            end else begin
                mem0[wr_addr] <= wr_word;
            end
        end
    end

    // Read side: leaving IDLE already emits j=0, so output starts one edge after the frame completes
    always_comb begin
        if (state_q == S_READ) begin
            rd_en   = 1'b1;
            rd_bank = rbank_q;
            rd_cnt  = rcnt_q;
        end else begin
            rd_en   = |full_q;
            rd_bank = ~full_q[0];
            rd_cnt  = 4'd0;
        end
        other_bank = ~rd_bank;
        rd_addr    = bitrev4(rd_cnt);
        rd_word    = rd_bank ? mem1[rd_addr] : mem0[rd_addr];
        full_pre   = full_q | full_set;

        full_clr    = 2'b00;
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        even_re_d   = even_re_q;
        even_im_d   = even_im_q;
        odd_re_d    = odd_re_q;
        odd_im_d    = odd_im_q;

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_first_d = (rd_cnt == 4'd0);
            even_re_d   = rd_word[4*WIDTH-1 -: WIDTH];
            even_im_d   = rd_word[3*WIDTH-1 -: WIDTH];
            odd_re_d    = rd_word[2*WIDTH-1 -: WIDTH];
            odd_im_d    = rd_word[WIDTH-1 -: WIDTH];
            if (rd_cnt == 4'd15) begin
                full_clr = rd_bank ? 2'b10 : 2'b01;
                rcnt_d   = 4'd0;
                // A frame finishing on this same edge counts, so READ runs on without a bubble
                if (full_pre[other_bank]) begin
                    state_d = S_READ;
                    rbank_d = other_bank;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                state_d = S_READ;
                rbank_d = rd_bank;
                rcnt_d  = rd_cnt + 4'd1;
            end
        end
        full_d = full_pre & ~full_clr;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 4'd0;
            rcnt_q      <= 4'd0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            even_re_q   <= '0;
            even_im_q   <= '0;
            odd_re_q    <= '0;
            odd_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            even_re_q   <= even_re_d;
            even_im_q   <= even_im_d;
            odd_re_q    <= odd_re_d;
            odd_im_q    <= odd_im_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_first  = out_first_q;
    assign bus.outEven_re = even_re_q;
    assign bus.outEven_im = even_im_q;
    assign bus.outOdd_re  = odd_re_q;
    assign bus.outOdd_im  = odd_im_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - scoreboard bench for fft_out_reorder
module tb_fft_out_reorder;
    localparam int W = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nout = 0;
    int   mcnt = 0;

    logic [2*W-1:0] frm [32];
    logic [4*W:0]   exp_q [$];
    int             cyc_q [$];

    fft_out_reorder_if #(.WIDTH(W)) bus ();

    fft_out_reorder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bitrev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    // Reference: rebuild natural-order bins from accepted pairs, queue the expected output per frame
    always @(posedge clk) begin
        int n;
        cyc = cyc + 1;
        if (!rst_n) begin
            mcnt = 0;
        end else if (bus.in_valid) begin
            if (bus.in_first) mcnt = 0;
            n = bitrev5(mcnt);
            frm[n]     = {bus.inUp_re, bus.inUp_im};
            frm[n + 1] = {bus.inL_re, bus.inL_im};
            mcnt++;
            if (mcnt == 16) begin
                for (int j = 0; j < 16; j++) begin
                    exp_q.push_back({(j == 0), frm[2*j], frm[2*j+1]});
                    cyc_q.push_back(cyc + 1 + j);
                end
                mcnt = 0;
            end
        end
    end

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        logic [4*W:0] e;
        int           c;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check_eq("pair", 64'({bus.out_first, bus.outEven_re, bus.outEven_im,
                                          bus.outOdd_re, bus.outOdd_im}), 64'(e));
                    check_eq("cycle", 64'(cyc), 64'(c));
                    nout++;
                end
            end else begin
                check_eq("first_wo_valid", 64'(bus.out_first), 64'd0);
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic send_frame(input int off, input bit gaps, input bit first, input bit ext,
                              input int npairs);
        int n;
        for (int k = 0; k < npairs; k++) begin
            if (gaps && k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    bus.in_valid = 1'b0;
                    bus.in_first = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            n = bitrev5(k);
            bus.in_valid = 1'b1;
            bus.in_first = first && (k == 0);
            if (ext) begin
                bus.inUp_re = (k % 2 == 0) ? -9'sd256 : 9'sd255;
                bus.inUp_im = (k % 2 == 0) ? 9'sd255 : -9'sd256;
                bus.inL_re  = (k % 2 == 0) ? 9'sd255 : -9'sd256;
                bus.inL_im  = (k % 2 == 0) ? -9'sd256 : 9'sd255;
            end else begin
                bus.inUp_re = W'(n + off);
                bus.inUp_im = W'(-(n + off));
                bus.inL_re  = W'(n + 1 + off);
                bus.inL_im  = W'(-(n + 1 + off));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int target;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.inUp_re  = '0;
        bus.inUp_im  = '0;
        bus.inL_re   = '0;
        bus.inL_im   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in", 64'({bus.out_valid, bus.out_first, bus.outEven_re, bus.outEven_im,
                                  bus.outOdd_re, bus.outOdd_im}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out", 64'({bus.out_valid, bus.out_first, bus.outEven_re, bus.outEven_im,
                                   bus.outOdd_re, bus.outOdd_im}), 64'd0);

        // Single frame
        send_frame(0, 1'b0, 1'b1, 1'b0, 16);
        idle();
        drain();

        // Three back-to-back frames, in_first only on the first
        send_frame(0, 1'b0, 1'b1, 1'b0, 16);
        send_frame(64, 1'b0, 1'b0, 1'b0, 16);
        send_frame(-128, 1'b0, 1'b0, 1'b0, 16);
        idle();
        drain();

        // Input gaps
        send_frame(0, 1'b1, 1'b1, 1'b0, 16);
        idle();
        drain();

        // Resync: partial frame discarded
        send_frame(100, 1'b0, 1'b1, 1'b0, 7);
        send_frame(-50, 1'b0, 1'b1, 1'b0, 16);
        idle();
        drain();

        // Extremes
        send_frame(0, 1'b0, 1'b1, 1'b1, 16);
        idle();
        drain();

        // Reset in the middle of a read, right after j=5 is presented
        target = nout + 6;
        send_frame(10, 1'b0, 1'b1, 1'b0, 16);
        idle();
        for (int i = 0; i < 100 && nout < target; i++) begin
            @(negedge clk);
            #2;
        end
        check_eq("reach_j5", 64'(nout >= target), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid", 64'({bus.out_valid, bus.out_first, bus.outEven_re, bus.outEven_im,
                                   bus.outOdd_re, bus.outOdd_im}), 64'd0);
        exp_q.delete();
        cyc_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Fresh frame after reset release
        send_frame(30, 1'b0, 1'b1, 1'b0, 16);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
